// File: rtl/sens_uart_rx.sv
// 16x-oversampling 8N1 serial byte receiver feeding the sensor frame parser.
// Synchronises rx, rejects short start glitches, votes 2-of-3 mid-bit and checks the stop bit.
module sens_uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_in_i,
  input  logic                 reset_i,
  input  logic                 clk_en_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_rdy_o,
  output logic                 frame_err_o
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                 state, state_n;
  logic [TW-1:0]          tick, tick_n;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic                   rx_p0, rx_p1;
  logic                   samp_a, samp_b;
  logic                   maj;
  logic                   shift_en, rdy_n, err_n;
  logic [DATA_BITS-1:0]   shift_q;

  // Stage p0/p1: two-flop synchroniser, runs every clock regardless of clk_en_i
  always_ff @(posedge clk_in_i) begin
    if (reset_i) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
    end
  end

  // The third vote is the live synced value at the decision tick
  always_ff @(posedge clk_in_i) begin
    if (clk_en_i && tick == T_S0) samp_a <= rx_p1;
    if (clk_en_i && tick == T_S1) samp_b <= rx_p1;
    if (shift_en) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
  end

  assign maj = maj3(samp_a, samp_b, rx_p1);

  always_ff @(posedge clk_in_i) begin
    if (reset_i) begin
      state       <= IDLE;
      tick        <= '0;
      bit_cnt     <= '0;
      data_o      <= '0;
      data_rdy_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      tick        <= tick_n;
      bit_cnt     <= bit_n;
      data_rdy_o  <= rdy_n;
      frame_err_o <= err_n;
      if (rdy_n) data_o <= shift_q;
    end
  end

  always_comb begin
    state_n  = state;
    tick_n   = tick;
    bit_n    = bit_cnt;
    shift_en = 1'b0;
    rdy_n    = 1'b0;
    err_n    = 1'b0;
    if (clk_en_i) begin
      case (state)
        IDLE: begin
          if (!rx_p1) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          tick_n = tick + 1'b1;
          if (tick == T_S2 && maj) begin
            state_n = IDLE;
            tick_n  = '0;
          end else if (tick == T_LAST) begin
            state_n = DATA;
            tick_n  = '0;
            bit_n   = '0;
          end
        end
        DATA: begin
          tick_n = tick + 1'b1;
          if (tick == T_S2) shift_en = 1'b1;
          if (tick == T_LAST) begin
            tick_n = '0;
            if (bit_cnt == B_LAST) begin
              state_n = STOP;
              bit_n   = '0;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          tick_n = tick + 1'b1;
          // Leave at the decision tick so a start bit right after the stop bit is caught
          if (tick == T_S2) begin
            tick_n = '0;
            if (maj) begin
              rdy_n   = 1'b1;
              state_n = IDLE;
            end else begin
              err_n   = 1'b1;
              state_n = BRK;
            end
          end
        end
        BRK: begin
          if (rx_p1) begin
            state_n = IDLE;
            tick_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sens_uart_rx.sv
// Directed bench for sens_uart_rx: one enable every 4 clocks, each bench tick is one enable period.
module tb_sens_uart_rx;

  logic       clk_in_i = 1'b0;
  logic       reset_i  = 1'b1;
  logic       clk_en_i = 1'b0;
  logic       rx_i     = 1'b1;
  logic [7:0] data_o;
  logic       data_rdy_o;
  logic       frame_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  int rdy_cnt = 0, err_cnt = 0, rdy_long = 0, err_long = 0, both_cnt = 0;
  logic rdy_prev = 1'b0, err_prev = 1'b0;
  logic [7:0] got[$];

  sens_uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk_in_i    (clk_in_i),
    .reset_i     (reset_i),
    .clk_en_i    (clk_en_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .data_rdy_o  (data_rdy_o),
    .frame_err_o (frame_err_o)
  );

  always #5 clk_in_i = ~clk_in_i;

  // Pulse monitor: counts strobes, pulses longer than one cycle and overlaps
  always @(negedge clk_in_i) begin
    if (data_rdy_o) begin
      rdy_cnt <= rdy_cnt + 1;
      got.push_back(data_o);
      if (rdy_prev) rdy_long <= rdy_long + 1;
    end
    if (frame_err_o) begin
      err_cnt <= err_cnt + 1;
      if (err_prev) err_long <= err_long + 1;
    end
    if (data_rdy_o && frame_err_o) both_cnt <= both_cnt + 1;
    rdy_prev <= data_rdy_o;
    err_prev <= frame_err_o;
  end

  task automatic do_tick(input logic v);
    rx_i = v;
    clk_en_i = 1'b0;
    repeat (3) @(posedge clk_in_i);
    #1 clk_en_i = 1'b1;
    @(posedge clk_in_i);
    #1 clk_en_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b1);
  endtask

  task automatic send_bit(input logic v);
    for (int t = 0; t < 16; t++) do_tick(v);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int b = 0; b < 8; b++) send_bit(d[b]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk_in_i);
    #1 reset_i = 1'b0;
    n_tests++;
    if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h expected 00", data_o); end
    n_tests++;
    if (data_rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", data_rdy_o); end
    n_tests++;
    if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err_o); end
  endtask

  task automatic test_frame();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    idle(8);
    send_frame(8'h52, 1'b1);
    idle(8);
    n_tests++;
    if (data_o !== 8'h52) begin n_fail++; $display("FAIL frame_data: got %0h expected 52", data_o); end
    n_tests++;
    if (rdy_cnt - r0 !== 1) begin n_fail++; $display("FAIL frame_rdy_count: got %0d expected 1", rdy_cnt - r0); end
    n_tests++;
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL frame_err_count: got %0d expected 0", err_cnt - e0); end
    n_tests++;
    if (rdy_long !== 0) begin n_fail++; $display("FAIL frame_rdy_width: got %0d long pulses expected 0", rdy_long); end
  endtask

  task automatic test_glitch();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    for (int i = 0; i < 3; i++) do_tick(1'b0);
    idle(30);
    n_tests++;
    if (rdy_cnt - r0 !== 0) begin n_fail++; $display("FAIL glitch_rdy: got %0d expected 0", rdy_cnt - r0); end
    n_tests++;
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_err: got %0d expected 0", err_cnt - e0); end
    send_frame(8'h31, 1'b1);
    idle(8);
    n_tests++;
    if (data_o !== 8'h31) begin n_fail++; $display("FAIL glitch_next_data: got %0h expected 31", data_o); end
    n_tests++;
    if (rdy_cnt - r0 !== 1) begin n_fail++; $display("FAIL glitch_next_rdy: got %0d expected 1", rdy_cnt - r0); end
  endtask

  task automatic test_break();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h35, 1'b0);
    for (int i = 0; i < 40; i++) do_tick(1'b0);
    idle(20);
    n_tests++;
    if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL break_err_count: got %0d expected 1", err_cnt - e0); end
    n_tests++;
    if (rdy_cnt - r0 !== 0) begin n_fail++; $display("FAIL break_rdy_count: got %0d expected 0", rdy_cnt - r0); end
    n_tests++;
    if (data_o !== 8'h31) begin n_fail++; $display("FAIL break_data_hold: got %0h expected 31", data_o); end
    n_tests++;
    if (err_long !== 0) begin n_fail++; $display("FAIL break_err_width: got %0d long pulses expected 0", err_long); end
    send_frame(8'h30, 1'b1);
    idle(8);
    n_tests++;
    if (data_o !== 8'h30) begin n_fail++; $display("FAIL break_next_data: got %0h expected 30", data_o); end
    n_tests++;
    if (rdy_cnt - r0 !== 1) begin n_fail++; $display("FAIL break_next_rdy: got %0d expected 1", rdy_cnt - r0); end
  endtask

  task automatic test_majority();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_bit(1'b0);
    for (int b = 0; b < 8; b++)
      for (int t = 0; t < 16; t++)
        do_tick((b == 3 && t == 9) ? 1'b1 : 1'b0);
    send_bit(1'b1);
    idle(8);
    n_tests++;
    if (data_o !== 8'h00) begin n_fail++; $display("FAIL majority_data: got %0h expected 00", data_o); end
    n_tests++;
    if (rdy_cnt - r0 !== 1) begin n_fail++; $display("FAIL majority_rdy: got %0d expected 1", rdy_cnt - r0); end
    n_tests++;
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL majority_err: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    int r0, e0, q0;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h52; exp_b[1] = 8'h31; exp_b[2] = 8'h32;
    r0 = rdy_cnt; e0 = err_cnt; q0 = got.size();
    for (int k = 0; k < 3; k++) send_frame(exp_b[k], 1'b1);
    idle(8);
    n_tests++;
    if (rdy_cnt - r0 !== 3) begin n_fail++; $display("FAIL b2b_rdy_count: got %0d expected 3", rdy_cnt - r0); end
    n_tests++;
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL b2b_err_count: got %0d expected 0", err_cnt - e0); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (got.size() <= q0 + k) begin
        n_fail++; $display("FAIL b2b_byte%0d: got none expected %0h", k, exp_b[k]);
      end else if (got[q0 + k] !== exp_b[k]) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %0h expected %0h", k, got[q0 + k], exp_b[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_bit(1'b0);
    for (int b = 0; b < 4; b++) send_bit(1'b1);
    for (int t = 0; t < 5; t++) do_tick(1'b1);
    reset_i = 1'b1;
    do_tick(1'b1);
    reset_i = 1'b0;
    n_tests++;
    if (data_o !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %0h expected 00", data_o); end
    for (int t = 0; t < 10; t++) do_tick(1'b1);
    for (int b = 0; b < 4; b++) send_bit(1'b1);
    send_bit(1'b1);
    idle(8);
    n_tests++;
    if (rdy_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin
      n_fail++; $display("FAIL rstmid_pulses: got rdy %0d err %0d expected 0 0", rdy_cnt - r0, err_cnt - e0);
    end
    send_frame(8'hA5, 1'b1);
    idle(8);
    n_tests++;
    if (data_o !== 8'hA5) begin n_fail++; $display("FAIL rstmid_next_data: got %0h expected a5", data_o); end
    n_tests++;
    if (rdy_cnt - r0 !== 1) begin n_fail++; $display("FAIL rstmid_next_rdy: got %0d expected 1", rdy_cnt - r0); end
    n_tests++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL overlap: got %0d overlapping pulses expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_glitch();
    test_break();
    test_majority();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
